scan_index_gen: RTL and testbench

SCAN_INDEX_GEN -- requirements
Module: scan_index_gen

---
 rtl/scan_index_gen.sv | 127 ++++++++++++
 tb/tb_scan_index_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/scan_index_gen.sv
// rtl/scan_index_gen.sv - strided modulo-32 index sequencer with valid/ready handshake
//
// Purpose:
//   Issues a scan of indices base, base+stride, base+2*stride, ... (wrapping
//   modulo 2**IDX_W) to a downstream one-hot decoder. One index is accepted
//   per valid/ready handshake. A scan ends with a single-cycle done pulse.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   start      in   1      scan request, sampled only in IDLE
//   base       in   IDX_W  first index of the scan
//   stride     in   IDX_W  increment per issued index (wraps)
//   count      in   IDX_W+1 number of indices; values above 2**IDX_W clamp
//   idx        out  IDX_W  current index (decoder select)
//   idx_valid  out  1      idx is valid
//   idx_ready  in   1      downstream accepts idx
//   busy       out  1      high in RUN and DONE
//   done       out  1      one-cycle pulse at scan end

module scan_index_gen #(
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] base,
    input  logic [IDX_W-1:0] stride,
    input  logic [IDX_W:0]   count,
    output logic [IDX_W-1:0] idx,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = IDX_W + 1;

    // A scan never issues more indices than the decoder has outputs.
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(1 << IDX_W);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [IDX_W-1:0] stride_q;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] eff_count;
    logic             handshake;
    logic             last_issue;

    assign eff_count  = (count > MAX_CNT) ? MAX_CNT : count;
    assign handshake  = idx_valid && idx_ready;
    assign last_issue = (remaining == CNT_W'(1));

    // All outputs decode directly from the state register, so an asynchronous
    // reset clears them in the same instant it clears the state.
    assign idx_valid = (state == ST_RUN);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (handshake && last_issue) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Scan datapath. In IDLE idx keeps the last issued value; scan parameters
    // are captured only on an accepted start so later input changes are inert.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            stride_q  <= '0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && (count != '0)) begin
                        idx       <= base;
                        stride_q  <= stride;
                        remaining <= eff_count;
                    end
                end
                ST_RUN: begin
                    if (handshake) begin
                        remaining <= remaining - CNT_W'(1);
                        // On the final handshake idx is left on the last issued
                        // value so IDLE presents it unchanged.
                        if (!last_issue) begin
                            idx <= idx + stride_q;
                        end
                    end
                end
                default: begin
                    remaining <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_index_gen.sv
// tb/tb_scan_index_gen.sv - randomized self-checking bench for scan_index_gen

module tb_scan_index_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] base;
    logic [4:0] stride;
    logic [5:0] count;
    logic [4:0] idx;
    logic       idx_valid;
    logic       idx_ready;
    logic       busy;
    logic       done;

    int n_tests;
    int n_fail;
    int last_idx;

    scan_index_gen #(.IDX_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base      (base),
        .stride    (stride),
        .count     (count),
        .idx       (idx),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Runs one scan starting at a negedge. Expected indices come from plain
    // arithmetic: k-th index = (b + k*s) mod 32, k < min(c, 32).
    // mode 0: ready always high; 1: random ready plus stray starts/inputs;
    // 2: ready low for 3 cycles while the second index is presented.
    task automatic run_scan(input int b, input int s, input int c, input int mode);
        int exp_q[$];
        int n;
        int got;
        int cycles;
        int stalls;
        int held;
        bit fin;
        n = (c > 32) ? 32 : c;
        for (int k = 0; k < n; k++) exp_q.push_back((b + k * s) % 32);

        start  = 1'b1;
        base   = 5'(b);
        stride = 5'(s);
        count  = 6'(c);
        @(negedge clk);
        start  = 1'b0;
        got    = 0;
        cycles = 0;
        stalls = 0;
        held   = 0;
        fin    = 0;
        while (!fin) begin
            if (done) begin
                fin = 1;
                check("done_valid_low", idx_valid, 0);
                check("done_busy", busy, 1);
                check("issued_count", got, n);
                check("scan_latency", cycles, n + stalls);
                start     = 1'b0;
                idx_ready = 1'b0;
            end else if (cycles > 300) begin
                fin = 1;
                check("scan_timeout", 0, 1);
            end else begin
                check("run_busy", busy, 1);
                check("run_valid", idx_valid, (got < n) ? 1 : 0);
                if (idx_valid && got < n) begin
                    check("run_idx", idx, exp_q[got]);
                end
                case (mode)
                    0: idx_ready = 1'b1;
                    1: idx_ready = ($urandom_range(0, 9) < 7);
                    default: begin
                        if (got == 1 && held < 3) begin
                            idx_ready = 1'b0;
                            held++;
                        end else begin
                            idx_ready = 1'b1;
                        end
                    end
                endcase
                if (mode == 1) begin
                    start  = ($urandom_range(0, 3) == 0);
                    base   = 5'($urandom);
                    stride = 5'($urandom);
                    count  = 6'($urandom);
                end
                if (idx_valid) begin
                    if (idx_ready) got++;
                    else stalls++;
                end
                @(negedge clk);
                cycles++;
            end
        end
        if (n > 0) last_idx = exp_q[n-1];
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_valid", idx_valid, 0);
        check("idle_idx_hold", idx, last_idx);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        last_idx  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        base      = '0;
        stride    = '0;
        count     = '0;
        idx_ready = 1'b0;
        #1;
        check("rst_idx", idx, 0);
        check("rst_valid", idx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);

        run_scan(3, 1, 4, 0);
        run_scan(30, 5, 3, 0);
        run_scan(0, 1, 40, 0);
        run_scan(9, 7, 6, 2);
        run_scan(7, 3, 0, 0);
        run_scan(12, 0, 5, 1);
        run_scan(31, 31, 33, 1);

        // Reset mid-scan: outputs clear at once, no done, fresh start works.
        start  = 1'b1;
        base   = 5'd4;
        stride = 5'd2;
        count  = 6'd20;
        idx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_valid_before_rst", idx_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_idx", idx, 0);
        check("mid_rst_valid", idx_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_done", done, 0);
        end
        rst = 1'b0;
        last_idx = 0;
        @(negedge clk);
        check("after_rst_idle", busy, 0);
        run_scan(5, 2, 10, 0);

        for (int t = 0; t < 30; t++) begin
            run_scan($urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 63), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
